rob_ctrl: RTL and testbench

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/util_pkg.sv | 78 +++++++
 rtl/rob_commit_sel.sv | 15 +
 rtl/rob_ctrl.sv | 136 +++++++++++++
 tb/tb_rob_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/util_pkg.sv
// Shared ROB types: entries, allocation requests, EX updates and ARF writeback records.
package util_pkg;
  localparam int ROB_INDEX_BITS = 3;

  typedef logic [ROB_INDEX_BITS-1:0] rob_idx_t;

  typedef struct packed {
    logic        valid;
    logic        pending;
    logic        flushed;
    logic        valid_exception;
    logic [4:0]  cause;
    logic        valid_dest;
    logic [4:0]  ldst;
    logic [5:0]  pdst;
    logic [5:0]  ppdst;
    logic [31:0] pc;
    logic [31:0] data;
  } rob_entry;

  typedef struct packed {
    logic        valid_request_1;
    logic        valid_dest_1;
    logic [4:0]  ldst_1;
    logic [5:0]  pdst_1;
    logic [5:0]  ppdst_1;
    logic [31:0] pc_1;
    logic        valid_request_2;
    logic        valid_dest_2;
    logic [4:0]  ldst_2;
    logic [5:0]  pdst_2;
    logic [5:0]  ppdst_2;
    logic [31:0] pc_2;
  } new_entries;

  typedef struct packed {
    logic     is_full;
    logic     two_empty;
    rob_idx_t ticket;
  } to_issue;

  typedef struct packed {
    logic        valid;
    rob_idx_t    ticket;
    logic [31:0] data;
    logic        valid_exception;
    logic [4:0]  cause;
  } ex_update;

  typedef struct packed {
    logic        valid;
    logic        valid_write;
    logic        flushed;
    logic        exception;
    logic [4:0]  cause;
    rob_idx_t    ticket;
    logic [4:0]  ldst;
    logic [5:0]  pdst;
    logic [5:0]  ppdst;
    logic [31:0] pc;
    logic [31:0] data;
  } writeback_toARF;

  function automatic rob_entry mk_entry(input logic vd, input logic [4:0] ldst,
                                        input logic [5:0] pdst, input logic [5:0] ppdst,
                                        input logic [31:0] pc);
    rob_entry e;
    e            = '0;
    e.valid      = 1'b1;
    e.pending    = 1'b1;
    e.valid_dest = vd;
    e.ldst       = ldst;
    e.pdst       = pdst;
    e.ppdst      = ppdst;
    e.pc         = pc;
    return e;
  endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// Retire decision for the two oldest ROB entries: 0, 1 or 2 commits this cycle.
module rob_commit_sel (
  input  logic head_vld,
  input  logic head_pend,
  input  logic head_exc,
  input  logic next_vld,
  input  logic next_pend,
  input  logic next_exc,
  output logic retire1_o,
  output logic retire2_o
);
  assign retire1_o = head_vld & ~head_pend;
  // An exception on either entry keeps it alone at the commit port.
  assign retire2_o = retire1_o & next_vld & ~next_pend & ~head_exc & ~next_exc;
endmodule

// File: rtl/rob_ctrl.sv
// Reorder buffer control: dual allocate, EX completion, in-order dual retire.
// Define ROB_FLUSH_EN to flush the whole ROB when an excepting entry reaches commit.
module rob_ctrl
  import util_pkg::*;
#(
  parameter int ROB_INDEX_BITS = util_pkg::ROB_INDEX_BITS
) (
  input  logic           clk,
  input  logic           rst,
  input  new_entries     alloc_i,
  output to_issue        issue_o,
  input  ex_update       ex_i,
  output writeback_toARF commit1_o,
  output writeback_toARF commit2_o
`ifdef ROB_FLUSH_EN
  ,
  output logic           flush_o,
  output logic [31:0]    flush_pc_o
`endif
);
  localparam int DEPTH = 1 << ROB_INDEX_BITS;
  localparam logic [ROB_INDEX_BITS:0] CNT_FULL = (ROB_INDEX_BITS+1)'(DEPTH);
  localparam logic [ROB_INDEX_BITS:0] CNT_TWO  = CNT_FULL - 2'd2;

  rob_entry                  rob_q [DEPTH];
  rob_entry                  rob_d [DEPTH];
  logic [ROB_INDEX_BITS-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [ROB_INDEX_BITS:0]   count_q, count_d, n_alloc, n_ret;
  logic                      is_full, two_empty, acc1, acc2, ret1, ret2, flush;
  rob_entry                  h_e, n_e;

  assign head_p1   = head_q + 1'b1;
  assign tail_p1   = tail_q + 1'b1;
  assign h_e       = rob_q[head_q];
  assign n_e       = rob_q[head_p1];
  assign is_full   = (count_q == CNT_FULL);
  assign two_empty = (count_q <= CNT_TWO);
  assign acc1      = alloc_i.valid_request_1 & ~is_full;
  assign acc2      = acc1 & alloc_i.valid_request_2 & two_empty;
  assign n_alloc   = {{ROB_INDEX_BITS{1'b0}}, acc1} + {{ROB_INDEX_BITS{1'b0}}, acc2};
  assign n_ret     = {{ROB_INDEX_BITS{1'b0}}, ret1} + {{ROB_INDEX_BITS{1'b0}}, ret2};

  assign issue_o.is_full   = is_full;
  assign issue_o.two_empty = two_empty;
  assign issue_o.ticket    = tail_q;

  rob_commit_sel u_sel (
    .head_vld  (h_e.valid),
    .head_pend (h_e.pending),
    .head_exc  (h_e.valid_exception),
    .next_vld  (n_e.valid),
    .next_pend (n_e.pending),
    .next_exc  (n_e.valid_exception),
    .retire1_o (ret1),
    .retire2_o (ret2)
  );

`ifdef ROB_FLUSH_EN
  assign flush      = ret1 & h_e.valid_exception;
  assign flush_o    = flush;
  assign flush_pc_o = flush ? h_e.pc : 32'h0;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    commit1_o = '0;
    commit2_o = '0;
    if (ret1) begin
      commit1_o.valid       = 1'b1;
      commit1_o.valid_write = h_e.valid_dest & ~flush;
      commit1_o.flushed     = h_e.flushed | flush;
      commit1_o.exception   = h_e.valid_exception;
      commit1_o.cause       = h_e.cause;
      commit1_o.ticket      = head_q;
      commit1_o.ldst        = h_e.ldst;
      commit1_o.pdst        = h_e.pdst;
      commit1_o.ppdst       = h_e.ppdst;
      commit1_o.pc          = h_e.pc;
      commit1_o.data        = h_e.data;
    end
    if (ret2) begin
      commit2_o.valid       = 1'b1;
      commit2_o.valid_write = n_e.valid_dest;
      commit2_o.flushed     = n_e.flushed;
      commit2_o.exception   = n_e.valid_exception;
      commit2_o.cause       = n_e.cause;
      commit2_o.ticket      = head_p1;
      commit2_o.ldst        = n_e.ldst;
      commit2_o.pdst        = n_e.pdst;
      commit2_o.ppdst       = n_e.ppdst;
      commit2_o.pc          = n_e.pc;
      commit2_o.data        = n_e.data;
    end
  end

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q + n_ret[ROB_INDEX_BITS-1:0];
    tail_d  = tail_q + n_alloc[ROB_INDEX_BITS-1:0];
    count_d = count_q + n_alloc - n_ret;
    // Completion is judged on registered state, so a freshly allocated slot ignores it.
    if (ex_i.valid && rob_q[ex_i.ticket].valid && rob_q[ex_i.ticket].pending) begin
      rob_d[ex_i.ticket].pending         = 1'b0;
      rob_d[ex_i.ticket].data            = ex_i.data;
      rob_d[ex_i.ticket].valid_exception = ex_i.valid_exception;
      rob_d[ex_i.ticket].cause           = ex_i.cause;
    end
    if (ret1) rob_d[head_q].valid = 1'b0;
    if (ret2) rob_d[head_p1].valid = 1'b0;
    if (acc1) rob_d[tail_q] = mk_entry(alloc_i.valid_dest_1, alloc_i.ldst_1,
                                       alloc_i.pdst_1, alloc_i.ppdst_1, alloc_i.pc_1);
    if (acc2) rob_d[tail_p1] = mk_entry(alloc_i.valid_dest_2, alloc_i.ldst_2,
                                        alloc_i.pdst_2, alloc_i.ppdst_2, alloc_i.pc_2);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) rob_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl; inputs change on negedge, outputs sampled 1ns later.
// The flush scenario is compiled in only with ROB_FLUSH_EN.
module tb_rob_ctrl;
  import util_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  new_entries     alloc;
  to_issue        issue;
  ex_update       ex;
  writeback_toARF c1, c2;
`ifdef ROB_FLUSH_EN
  logic           flush;
  logic [31:0]    flush_pc;
`endif
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rob_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_i   (alloc),
    .issue_o   (issue),
    .ex_i      (ex),
    .commit1_o (c1),
    .commit2_o (c2)
`ifdef ROB_FLUSH_EN
    ,
    .flush_o   (flush),
    .flush_pc_o(flush_pc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic req1(input logic [4:0] ld, input logic [31:0] pc);
    alloc.valid_request_1 = 1'b1;
    alloc.valid_dest_1    = 1'b1;
    alloc.ldst_1          = ld;
    alloc.pdst_1          = {1'b1, ld};
    alloc.ppdst_1         = {1'b0, ld};
    alloc.pc_1            = pc;
  endtask

  task automatic req2(input logic [4:0] ld, input logic [31:0] pc);
    alloc.valid_request_2 = 1'b1;
    alloc.valid_dest_2    = 1'b1;
    alloc.ldst_2          = ld;
    alloc.pdst_2          = {1'b1, ld};
    alloc.ppdst_2         = {1'b0, ld};
    alloc.pc_2            = pc;
  endtask

  task automatic upd(input logic [2:0] t, input logic [31:0] d, input logic exc);
    ex.valid           = 1'b1;
    ex.ticket          = t;
    ex.data            = d;
    ex.valid_exception = exc;
    ex.cause           = exc ? 5'd3 : 5'd0;
  endtask

  task automatic idle();
    alloc = '0;
    ex    = '0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_full", issue.is_full, 0);
    chk("rst_two_empty", issue.two_empty, 1);
    chk("rst_ticket", issue.ticket, 0);
    chk("rst_c1", c1, 0);
    chk("rst_c2", c2, 0);
    step();
    rst = 1'b0;

    // Dual allocate lreg 1,2 -> tickets 0,1
    req1(5'd1, 32'h10); req2(5'd2, 32'h14);
    #1 chk("alloc2_ticket0", issue.ticket, 0);
    step(); #1;
    chk("alloc2_tail", issue.ticket, 2);
    chk("alloc2_two_empty", issue.two_empty, 1);
    chk("alloc2_full", issue.is_full, 0);

    // Out-of-order completion: 1 then 0
    upd(3'd1, 32'hB, 1'b0);
    step(); #1;
    chk("ooo_no_commit", c1.valid, 0);
    upd(3'd0, 32'hA, 1'b0);
    #1 chk("no_forward", c1.valid, 0);
    step(); #1;
    chk("c1_valid", c1.valid, 1);
    chk("c1_ticket", c1.ticket, 0);
    chk("c1_data", c1.data, 32'hA);
    chk("c1_ldst", c1.ldst, 1);
    chk("c1_vwrite", c1.valid_write, 1);
    chk("c2_valid", c2.valid, 1);
    chk("c2_ticket", c2.ticket, 1);
    chk("c2_data", c2.data, 32'hB);
    step(); #1;
    chk("after_commit_c1", c1.valid, 0);
    chk("after_commit_tail", issue.ticket, 2);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // Fill with 8 single allocations
    for (int i = 0; i < 8; i++) begin
      req1(5'(i), 32'h0FC + 32'(4 * i));
      step(); #1;
      if (i == 5) chk("fill6_two_empty", issue.two_empty, 1);
      if (i == 6) chk("fill7_two_empty", issue.two_empty, 0);
      if (i == 6) chk("fill7_full", issue.is_full, 0);
    end
    chk("fill8_full", issue.is_full, 1);
    chk("fill8_tail", issue.ticket, 0);
    req1(5'd9, 32'h300);
    step(); #1;
    chk("ninth_full", issue.is_full, 1);
    chk("ninth_tail", issue.ticket, 0);

    // Full ROB retires head while a request arrives
    upd(3'd0, 32'h55, 1'b0);
    step();
    req1(5'd10, 32'h200);
    #1;
    chk("fullret_c1", c1.valid, 1);
    chk("fullret_ticket", c1.ticket, 0);
    chk("fullret_c2", c2.valid, 0);
    chk("fullret_full", issue.is_full, 1);
    step(); #1;
    chk("cnt7_full", issue.is_full, 0);
    chk("cnt7_two_empty", issue.two_empty, 0);
    chk("cnt7_tail", issue.ticket, 0);
    req1(5'd10, 32'h200);
    step(); #1;
    chk("realloc_full", issue.is_full, 1);
    chk("realloc_tail", issue.ticket, 1);

    // Ticket 2 completes, then ticket 1 with an exception
    upd(3'd2, 32'h22, 1'b0);
    step();
    upd(3'd1, 32'h11, 1'b1);
    step(); #1;
    chk("exc_c1", c1.valid, 1);
    chk("exc_c1_ticket", c1.ticket, 1);
    chk("exc_c2_blocked", c2.valid, 0);
`ifdef ROB_FLUSH_EN
    chk("flush_flushed", c1.flushed, 1);
    chk("flush_vwrite", c1.valid_write, 0);
    chk("flush_o", flush, 1);
    chk("flush_pc", flush_pc, 32'h100);
    step(); #1;
    chk("flush_pulse_end", flush, 0);
    chk("flush_tail", issue.ticket, 0);
    chk("flush_full", issue.is_full, 0);
    chk("flush_two_empty", issue.two_empty, 1);
    chk("flush_c1", c1.valid, 0);
`else
    chk("exc_vwrite", c1.valid_write, 1);
    chk("exc_flag", c1.exception, 1);
    chk("exc_pc", c1.pc, 32'h100);
    step(); #1;
    chk("after_exc_c1", c1.valid, 1);
    chk("after_exc_ticket", c1.ticket, 2);
    chk("after_exc_data", c1.data, 32'h22);
    chk("after_exc_c2", c2.valid, 0);
`endif

    // Reset with five pending entries and traffic in flight
    rst = 1'b1;
    step();
    rst = 1'b0;
    req1(5'd1, 32'h40); req2(5'd2, 32'h44);
    step();
    req1(5'd3, 32'h48); req2(5'd4, 32'h4C);
    step();
    req1(5'd5, 32'h50);
    step(); #1;
    chk("cnt5_tail", issue.ticket, 5);
    chk("cnt5_two_empty", issue.two_empty, 1);
    upd(3'd0, 32'h77, 1'b0);
    req1(5'd6, 32'h54); req2(5'd7, 32'h58);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tail", issue.ticket, 0);
    chk("midrst_full", issue.is_full, 0);
    chk("midrst_two_empty", issue.two_empty, 1);
    chk("midrst_c1", c1, 0);
    step();
    rst = 1'b0;
    step(); #1;
    chk("postrst_c1", c1.valid, 0);
    chk("postrst_tail", issue.ticket, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
